game_sequencer: RTL and testbench
=================================

# game_sequencer

Game-flow controller for the side-scrolling obstacle game. Owns the obstacle position fed to the graphics block: it steps the obstacle right-to-left at a programmable rate and speeds up after every pass. It also tracks the player's jump, detects collisions, keeps score and sequences IDLE → RUN → OVER. It sits between the board inputs (start/jump keys) and the Graphics renderer, replacing free-running position logic in the top level.

## Interface
Parameters:
- X_START, 160: obstacle x at the start of each pass.
- Y_LANE, 120: ground-lane y for obstacle and grounded player.
- DELAY_INIT, 5000000: initial clk cycles per obstacle step.
- DELAY_STEP, 500000: delay decrement applied after each completed pass.
- DELAY_MIN, 1000000: floor for the step delay.
- PLAYER_X, 20: left edge of the player hit window.
- HIT_W, 8: hit-window width in x units.
- JUMP_TICKS, 40: obstacle steps the player stays airborne.
- JUMP_H, 16: player y lift while airborne.

Ports:
- clk, in, 1: system clock (CLOCK_50 domain).
- reset, in, 1: synchronous, active-high reset.
- start, in, 1: level; begins or restarts a game from IDLE/OVER.
- jump, in, 1: level; requests a jump while running.
- obstacle_x, out, 9: obstacle x offset to Graphics.
- obstacle_y, out, 8: obstacle y offset; constant Y_LANE.
- player_y, out, 8: player y; Y_LANE or Y_LANE−JUMP_H.
- score, out, 8: completed passes, saturating at 255.
- move_tick, out, 1: one-cycle pulse, high in the cycle the new obstacle_x first appears.
- running, out, 1: high in RUN.
- game_over, out, 1: high in OVER.

## Operation
- States: IDLE, RUN, OVER.
- Reset (all values in the cycle after reset is sampled):
  - State is IDLE.
  - obstacle_x=X_START, obstacle_y=Y_LANE, player_y=Y_LANE, score=0.
  - move_tick=0, running=0, game_over=0, airborne=0.
  - cur_delay=DELAY_INIT.
  - Reset overrides every other input.
- IDLE/OVER with start=1 → RUN next cycle, with a full re-initialization:
  - obstacle_x=X_START, score=0, cur_delay=DELAY_INIT.
  - airborne cleared; step counter loaded with DELAY_INIT−1.
  - start is ignored while in RUN.
- Step timer (RUN only):
  - 24-bit down counter. At 0 it fires a step and reloads cur_delay−1, so the step period equals cur_delay cycles.
  - The counter is frozen outside RUN.
- On each step:
  - obstacle_x≠0: obstacle_x decrements by 1.
  - obstacle_x==0:
    - obstacle_x reloads X_START.
    - score increments, saturating at 255.
    - cur_delay ← max(cur_delay−DELAY_STEP, DELAY_MIN). The new value is used by the reload in that same cycle.
    - The delay never wraps, and never drops below DELAY_MIN.
- Jump:
  - In RUN, jump=1 with airborne=0 sets airborne=1 and air_cnt=JUMP_TICKS.
  - jump is ignored while airborne; holding jump retriggers a jump immediately on landing.
  - Each step decrements air_cnt. The step that takes air_cnt from 1 to 0 clears airborne.
  - player_y is registered and equals Y_LANE−JUMP_H when airborne, otherwise Y_LANE.
- Collision is checked every RUN cycle on registered values:
  - Condition: PLAYER_X ≤ obstacle_x < PLAYER_X+HIT_W and airborne=0.
  - On a hit, the next state is OVER.
  - A jump asserted in the same cycle as a hit does not prevent it; collision wins.
- OVER:
  - obstacle_x, player_y and score are frozen.
  - game_over=1, move_tick=0.

## Timing
- One clk domain; all outputs registered; no combinational input-to-output path.
- Start latency: start sampled in cycle n → running=1 in n+1. The first move_tick occurs at n+1+DELAY_INIT.
- Collision latency: the offending obstacle_x is visible in cycle m → game_over=1 in m+1.
- move_tick is high in exactly the cycle obstacle_x takes its new value.
- Score increment and the obstacle wrap to X_START happen in the same cycle.
- Arithmetic:
  - Delay math is 24-bit unsigned, with the compare done before the subtract so there is no underflow.
  - obstacle_x is 9-bit and never decrements below 0.

## Structure
- Shared package game_pkg holds:
  - state enum (IDLE, RUN, OVER);
  - default constants X_START, Y_LANE, DELAY_INIT, DELAY_STEP, DELAY_MIN;
  - width localparams: X_W=9, Y_W=8, DLY_W=24.
- One sub-module, step_timer: a reloadable 24-bit down counter with enable, a load value and a one-cycle fire output.
- FSM, position, jump, score and collision logic live in game_sequencer.

## Test plan
Bench parameters: DELAY_INIT=4, DELAY_STEP=1, DELAY_MIN=2, X_START=10, PLAYER_X=2, HIT_W=2, JUMP_TICKS=3, JUMP_H=16.
- Reset mid-RUN (obstacle_x=5), reset held one cycle → next cycle: IDLE, obstacle_x=10, score=0, player_y=120, move_tick=0.
- Pulse start, keep jump high throughout → running=1 next cycle; move_tick every 4 cycles; obstacle_x steps 10,9,…,0,10; score=1 at the wrap.
- Keep jump high throughout and run three passes → step spacing 4, then 3, then 2, then stays at 2 (floor, no wrap).
- No jump → obstacle_x=3 appears → game_over=1 next cycle; obstacle_x frozen at 3; score unchanged.
- Pulse jump while obstacle_x=4 → player_y=104, airborne for exactly 3 steps (obstacle_x=3,2,1); no hit; player_y=120 when obstacle_x reaches 1.
- Jump asserted in the same cycle obstacle_x=3 first appears → OVER (collision wins). Then pulse start → RUN with score=0 and obstacle_x=10.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: shared state type, default constants and widths for the game sequencer.
package game_pkg;
  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;
  localparam int X_W = 9;
  localparam int Y_W = 8;
  localparam int DLY_W = 24;
  localparam int X_START = 160;
  localparam int Y_LANE = 120;
  localparam int DELAY_INIT = 5000000;
  localparam int DELAY_STEP = 500000;
  localparam int DELAY_MIN = 1000000;
endpackage

// File: rtl/game_sequencer_step_timer.sv
// step_timer: reloadable down counter firing for one cycle at zero, then reloading period-1.
module step_timer
  import game_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [DLY_W-1:0] period,
  output logic             fire
);
  logic [DLY_W-1:0] cnt;
  assign fire = en && cnt == '0;
  always_ff @(posedge clk)
    if (reset) cnt <= '0;
    else if (load || fire) cnt <= period - DLY_W'(1);
    else if (en) cnt <= cnt - DLY_W'(1);
endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: obstacle stepping, jump, collision, score and IDLE/RUN/OVER flow.
module game_sequencer #(
  parameter int X_START    = game_pkg::X_START,
  parameter int Y_LANE     = game_pkg::Y_LANE,
  parameter int DELAY_INIT = game_pkg::DELAY_INIT,
  parameter int DELAY_STEP = game_pkg::DELAY_STEP,
  parameter int DELAY_MIN  = game_pkg::DELAY_MIN,
  parameter int PLAYER_X   = 20,
  parameter int HIT_W      = 8,
  parameter int JUMP_TICKS = 40,
  parameter int JUMP_H     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     jump,
  output logic [game_pkg::X_W-1:0] obstacle_x,
  output logic [game_pkg::Y_W-1:0] obstacle_y,
  output logic [game_pkg::Y_W-1:0] player_y,
  output logic [7:0]               score,
  output logic                     move_tick,
  output logic                     running,
  output logic                     game_over
);
  import game_pkg::*;
  state_t state, state_n;
  logic [DLY_W-1:0] cur_delay, next_delay, period;
  logic [7:0] air_cnt, cnt_n;
  logic airborne, air_n, take_off, fire, hit, act, wrap, restart;
  assign running = state == RUN;
  assign game_over = state == OVER;
  assign obstacle_y = Y_W'(Y_LANE);
  assign restart = state != RUN && start;
  assign hit = running && !airborne && obstacle_x >= X_W'(PLAYER_X) && obstacle_x < X_W'(PLAYER_X + HIT_W);
  assign act = running && !hit;
  assign wrap = fire && obstacle_x == '0;
  // compare before subtracting so the delay can never underflow
  assign next_delay = !wrap ? cur_delay :
                      ({8'd0, cur_delay} >= 32'(DELAY_MIN + DELAY_STEP)) ? cur_delay - DLY_W'(DELAY_STEP) :
                      DLY_W'(DELAY_MIN);
  assign period = restart ? DLY_W'(DELAY_INIT) : next_delay;
  assign take_off = jump && !airborne;
  assign cnt_n = take_off ? 8'(JUMP_TICKS) : (airborne && fire) ? air_cnt - 8'd1 : air_cnt;
  assign air_n = take_off || (airborne && !(fire && air_cnt == 8'd1));
  always_comb begin
    state_n = state;
    if (restart) state_n = RUN;
    else if (hit) state_n = OVER;
  end
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  step_timer u_timer (
    .clk   (clk),
    .reset (reset),
    .en    (act),
    .load  (restart),
    .period(period),
    .fire  (fire)
  );
  always_ff @(posedge clk)
    if (reset) begin
      obstacle_x <= X_W'(X_START);
      player_y <= Y_W'(Y_LANE);
      score <= '0;
      move_tick <= 1'b0;
      cur_delay <= DLY_W'(DELAY_INIT);
      airborne <= 1'b0;
      air_cnt <= '0;
    end else begin
      move_tick <= act && fire;
      if (restart) begin
        obstacle_x <= X_W'(X_START);
        player_y <= Y_W'(Y_LANE);
        score <= '0;
        cur_delay <= DLY_W'(DELAY_INIT);
        airborne <= 1'b0;
        air_cnt <= '0;
      end else if (act) begin
        cur_delay <= next_delay;
        airborne <= air_n;
        air_cnt <= cnt_n;
        player_y <= air_n ? Y_W'(Y_LANE - JUMP_H) : Y_W'(Y_LANE);
        if (fire) obstacle_x <= wrap ? X_W'(X_START) : obstacle_x - X_W'(1);
        if (wrap && score != 8'hff) score <= score + 8'd1;
      end
    end
endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed scenarios plus random traffic against a cycle-level game model.
module tb_game_sequencer;
  localparam int XS = 10, YL = 120, DI = 4, DS = 1, DM = 2, PX = 2, HW = 2, JT = 3, JH = 16;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, jump = 1'b0;
  logic [8:0] obstacle_x;
  logic [7:0] obstacle_y, player_y, score;
  logic move_tick, running, game_over;
  int n_chk = 0, n_fail = 0;
  int m_st = 0, m_x = XS, m_score = 0, m_delay = DI, m_el = 0, m_air = 0, m_tick = 0;
  int edge_n = 0, last_edge = 0, ps = 0;

  game_sequencer #(.X_START(XS), .Y_LANE(YL), .DELAY_INIT(DI), .DELAY_STEP(DS), .DELAY_MIN(DM),
                   .PLAYER_X(PX), .HIT_W(HW), .JUMP_TICKS(JT), .JUMP_H(JH)) dut (
    .clk(clk), .reset(reset), .start(start), .jump(jump),
    .obstacle_x(obstacle_x), .obstacle_y(obstacle_y), .player_y(player_y), .score(score),
    .move_tick(move_tick), .running(running), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, int got, int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  function automatic int gap_for(int s);
    int g = DI - DS * s;
    return g < DM ? DM : g;
  endfunction

  // model: m_st 0=idle 1=run 2=over; m_el counts cycles since the last step
  task automatic model_edge(bit r, bit s, bit j);
    bit stp;
    m_tick = 0;
    if (r) begin
      m_st = 0; m_x = XS; m_score = 0; m_delay = DI; m_air = 0;
    end else if (m_st != 1) begin
      if (s) begin
        m_st = 1; m_x = XS; m_score = 0; m_delay = DI; m_air = 0; m_el = 0; last_edge = edge_n;
      end
    end else if (m_x >= PX && m_x < PX + HW && m_air == 0) begin
      m_st = 2;
    end else begin
      stp = (m_el == m_delay - 1);
      m_el = stp ? 0 : m_el + 1;
      m_tick = stp;
      if (j && m_air == 0) m_air = JT;
      else if (m_air > 0 && stp) m_air--;
      if (stp) begin
        if (m_x == 0) begin
          m_x = XS;
          m_score = m_score < 255 ? m_score + 1 : 255;
          m_delay = (m_delay - DS < DM) ? DM : m_delay - DS;
        end else m_x--;
      end
    end
  endtask

  task automatic cyc(bit r, bit s, bit j);
    reset = r; start = s; jump = j;
    @(posedge clk);
    edge_n++;
    ps = m_score;
    model_edge(r, s, j);
    #1;
    check("obstacle_x", obstacle_x, m_x);
    check("obstacle_y", obstacle_y, YL);
    check("player_y", player_y, m_air > 0 ? YL - JH : YL);
    check("score", score, m_score);
    check("move_tick", move_tick, m_tick);
    check("running", running, m_st == 1);
    check("game_over", game_over, m_st == 2);
    if (m_tick != 0 && !r) begin
      check("step_gap", edge_n - last_edge, gap_for(ps));
      last_edge = edge_n;
    end
  endtask

  initial begin
    cyc(1, 0, 0); cyc(1, 0, 0);
    repeat (3) cyc(0, 0, 0);
    cyc(0, 1, 1);
    check("run_after_start", running, 1);
    for (int i = 0; i < 200 && m_score < 1; i++) cyc(0, 0, 1);
    if (m_score < 1) check("pass1_timeout", 0, 1);
    check("wrap_score", score, 1);
    check("wrap_x", obstacle_x, XS);
    check("wrap_tick", move_tick, 1);
    for (int i = 0; i < 400 && m_score < 4; i++) cyc(0, 0, m_x == 4);
    check("score_4_passes", score, 4);
    for (int i = 0; i < 100 && m_st != 2; i++) cyc(0, 0, 0);
    check("hit_over", game_over, 1);
    check("hit_x", obstacle_x, 3);
    check("hit_score", score, 4);
    repeat (5) cyc(0, 0, 1);
    check("over_x_frozen", obstacle_x, 3);
    check("over_player_y", player_y, YL);
    check("over_tick", move_tick, 0);
    cyc(0, 1, 0);
    check("restart_score", score, 0);
    check("restart_x", obstacle_x, XS);
    for (int i = 0; i < 100 && m_x != 4; i++) cyc(0, 0, 0);
    cyc(0, 0, 1);
    check("jump_up", player_y, YL - JH);
    for (int i = 0; i < 100 && m_x != 1; i++) begin
      cyc(0, 0, 0);
      if (move_tick && (obstacle_x == 3 || obstacle_x == 2)) check("air_over_window", player_y, YL - JH);
    end
    check("land_at_1", player_y, YL);
    check("no_hit_jump", running, 1);
    for (int i = 0; i < 100 && !(m_x == 3 && m_tick != 0); i++) cyc(0, 0, 0);
    cyc(0, 0, 1);
    check("jump_vs_hit_over", game_over, 1);
    check("jump_vs_hit_y", player_y, YL);
    cyc(0, 1, 0);
    check("restart2_score", score, 0);
    check("restart2_x", obstacle_x, XS);
    for (int i = 0; i < 300 && !(m_score == 1 && m_x == 5); i++) cyc(0, 0, m_x == 4);
    check("pre_reset_x", obstacle_x, 5);
    cyc(1, 0, 0);
    check("rst_running", running, 0);
    check("rst_x", obstacle_x, XS);
    check("rst_score", score, 0);
    check("rst_tick", move_tick, 0);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 499) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
